// File: rtl/axi_sram_responder_if.sv
// AXI-style burst bus (address, write data, write response, read channels)
// carrying INCR bursts between a master and a memory-mapped slave.
interface axi_interface #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        input  araddr, arlen, arvalid, rready,
        output awready, wready, bvalid, arready, rdata, rvalid
    );

    modport master (
        output awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        output araddr, arlen, arvalid, rready,
        input  awready, wready, bvalid, arready, rdata, rvalid
    );
endinterface

// File: rtl/axi_sram_responder.sv
// Single-clock AXI burst slave backed by a synchronous RAM; serves one
// write or read burst at a time with round-robin arbitration between them.
module axi_sram_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 1024
) (
    input logic        clk,
    input logic        reset,
    axi_interface.slave axi_bus
);
    localparam int unsigned OFF = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IW  = $clog2(MEM_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        WRITE_BURST,
        WRITE_RESP,
        READ_FETCH,
        READ_BURST
    } state_t;

    state_t                state, state_next;
    logic [IW-1:0]         idx, idx_next;
    logic [7:0]            remaining, remaining_next;
    logic                  prio_write, prio_write_next;
    logic                  grant_w, grant_r;
    logic                  mem_we, rd_en;
    logic [IW-1:0]         rd_addr;
    logic                  awready, arready, wready, bvalid, rvalid;
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  unused;

    assign unused = &{1'b0, axi_bus.wlast, axi_bus.awaddr, axi_bus.araddr};

    // prio_write selects the winner only when both directions request.
    assign grant_w = axi_bus.awvalid && (!axi_bus.arvalid || prio_write);
    assign grant_r = axi_bus.arvalid && (!axi_bus.awvalid || !prio_write);

    always_comb begin
        state_next      = state;
        idx_next        = idx;
        remaining_next  = remaining;
        prio_write_next = prio_write;
        awready         = 1'b0;
        arready         = 1'b0;
        wready          = 1'b0;
        bvalid          = 1'b0;
        rvalid          = 1'b0;
        mem_we          = 1'b0;
        rd_en           = 1'b0;
        rd_addr         = idx;
        case (state)
            IDLE: begin
                if (grant_w) begin
                    awready         = 1'b1;
                    idx_next        = axi_bus.awaddr[OFF +: IW];
                    remaining_next  = axi_bus.awlen;
                    prio_write_next = 1'b0;
                    state_next      = WRITE_BURST;
                end else if (grant_r) begin
                    arready         = 1'b1;
                    idx_next        = axi_bus.araddr[OFF +: IW];
                    remaining_next  = axi_bus.arlen;
                    prio_write_next = 1'b1;
                    state_next      = READ_FETCH;
                end
            end
            WRITE_BURST: begin
                wready = 1'b1;
                if (axi_bus.wvalid) begin
                    mem_we         = 1'b1;
                    idx_next       = idx + 1'b1;
                    remaining_next = remaining - 8'd1;
                    if (remaining == 8'd0) begin
                        state_next = WRITE_RESP;
                    end
                end
            end
            WRITE_RESP: begin
                bvalid = 1'b1;
                if (axi_bus.bready) begin
                    state_next = IDLE;
                end
            end
            READ_FETCH: begin
                rd_en      = 1'b1;
                state_next = READ_BURST;
            end
            READ_BURST: begin
                rvalid = 1'b1;
                if (axi_bus.rready) begin
                    if (remaining == 8'd0) begin
                        state_next = IDLE;
                    end else begin
                        // Prefetch the next word so beats stream at full rate.
                        rd_en          = 1'b1;
                        rd_addr        = idx + 1'b1;
                        idx_next       = idx + 1'b1;
                        remaining_next = remaining - 8'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prio_write <= 1'b0;
            idx        <= '0;
            remaining  <= '0;
        end else begin
            state      <= state_next;
            prio_write <= prio_write_next;
            idx        <= idx_next;
            remaining  <= remaining_next;
        end
    end

    // rdata_q only changes on a fetch, which holds rdata across stalls.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[idx] <= axi_bus.wdata;
        end
        if (rd_en && !reset) begin
            rdata_q <= mem[rd_addr];
        end
    end

    assign axi_bus.awready = awready;
    assign axi_bus.arready = arready;
    assign axi_bus.wready  = wready;
    assign axi_bus.bvalid  = bvalid;
    assign axi_bus.rvalid  = rvalid;
    assign axi_bus.rdata   = rdata_q;
endmodule
